// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush sequencer merging load-use, branch flush and data-memory miss handling.
module pipeline_stall_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int COUNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               load_use_i,
    input  logic               flush_i,
    input  logic               mem_access_i,
    input  logic               mem_hit_i,
    input  logic               mem_ack_i,
    output logic               pc_write_o,
    output logic               ifid_write_o,
    output logic               ifid_flush_o,
    output logic               idex_bubble_o,
    output logic               stall_all_o,
    output logic               mem_req_o,
    output logic               mem_err_o,
    output logic [COUNT_W-1:0] stall_cnt_o,
    output logic [COUNT_W-1:0] flush_cnt_o
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RUN    = 3'd1;
    localparam logic [2:0] MISS   = 3'd2;
    localparam logic [2:0] RESUME = 3'd3;
    localparam logic [2:0] HALT   = 3'd4;
    logic [2:0]    state, state_nxt;
    logic [WW-1:0] wait_cnt;
    logic          miss, active, timeout, ld_stall;
    always_comb begin
        miss          = (state == RUN) & mem_access_i & ~mem_hit_i;
        timeout       = wait_cnt == WW'(TIMEOUT);
        stall_all_o   = (state == IDLE) | (state == HALT) | (state == MISS) | miss;
        active        = ((state == RUN) | (state == RESUME)) & ~stall_all_o;
        ifid_flush_o  = active & flush_i;
        idex_bubble_o = active & (flush_i | load_use_i);
        pc_write_o    = active & (flush_i | ~load_use_i);
        ifid_write_o  = pc_write_o;
        ld_stall      = active & load_use_i & ~flush_i;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start_i ? RUN : IDLE;
            RUN:     state_nxt = miss ? MISS : RUN;
            MISS:    state_nxt = mem_ack_i ? RESUME : (timeout ? HALT : MISS);
            RESUME:  state_nxt = RUN;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end
    // Wait counter reads 1 in the first MISS cycle; an ack on the TIMEOUT cycle still wins.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            mem_req_o   <= 1'b0;
            mem_err_o   <= 1'b0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= miss ? WW'(1) :
                           (state == MISS && !mem_ack_i && !timeout) ? wait_cnt + WW'(1) :
                           (state == RESUME) ? '0 : wait_cnt;
            mem_req_o   <= miss;
            mem_err_o   <= mem_err_o | ((state == MISS) & ~mem_ack_i & timeout);
            if ((stall_all_o || ld_stall) && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + COUNT_W'(1);
            if (ifid_flush_o && flush_cnt_o != '1)
                flush_cnt_o <= flush_cnt_o + COUNT_W'(1);
        end
    end
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Merges three inputs into one set of pipeline-register enables:
  - load-use hazard request from the hazard detection stage;
  - branch-flush request from ID;
  - data-memory miss handshake from MEM.
- Owns the multi-cycle miss FSM, the miss timeout and the stall/flush performance counters.

Parameters:
TIMEOUT, 64, max cycles waiting for mem_ack_i before fatal error (≥2)
COUNT_W, 16, width of saturating performance counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
start_i  in  1  leave IDLE and begin execution
load_use_i  in  1  load-use hazard request (stall IF/ID, bubble ID/EX)
flush_i  in  1  branch taken in ID (flush IF/ID, bubble ID/EX)
mem_access_i  in  1  instruction in MEM reads or writes data memory
mem_hit_i  in  1  data memory can complete access this cycle
mem_ack_i  in  1  refill/writeback complete, one-cycle pulse
pc_write_o  out  1  PC update enable
ifid_write_o  out  1  IF/ID register enable
ifid_flush_o  out  1  IF/ID clear to NOP
idex_bubble_o  out  1  select zero control into ID/EX
stall_all_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM, MEM/WB
mem_req_o  out  1  registered one-cycle miss request to memory
mem_err_o  out  1  sticky timeout error
stall_cnt_o  out  COUNT_W  cycles with stall_all_o or load-use stall
flush_cnt_o  out  COUNT_W  cycles with ifid_flush_o

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE; mem_req_o=0; mem_err_o=0; wait counter=0; both perf counters=0.
- States: IDLE, RUN, MISS, RESUME, HALT.
- IDLE:
  - stall_all_o=1, pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=0.
  - start_i=1 → RUN next cycle.
- RUN:
  - Miss = mem_access_i & ~mem_hit_i. On a miss: stall_all_o=1 combinationally that same cycle; next state MISS; mem_req_o=1 registered, high only in the first MISS cycle.
  - No miss, flush_i=1: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1, idex_bubble_o=1. Flush wins over load_use_i.
  - No miss, load_use_i=1, flush_i=0: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0.
  - Otherwise: pc_write_o=1, ifid_write_o=1, all others 0.
- Any cycle with stall_all_o=1 forces pc_write_o=ifid_write_o=ifid_flush_o=idex_bubble_o=0. Pending flush/load-use is deferred; its inputs stay stable because the pipeline is frozen.
- MISS:
  - stall_all_o=1. Wait counter increments each cycle starting at 1.
  - mem_ack_i=1 → RESUME next cycle; the ack cycle itself is still stalled.
  - If the counter reaches TIMEOUT without an ack → HALT; mem_err_o=1 from the next cycle.
  - Ack arriving in the same cycle the counter reaches TIMEOUT counts as success (→ RESUME).
- RESUME (exactly one cycle):
  - stall_all_o=0; miss detection suppressed (refill data valid); flush/load-use rules as in RUN.
  - Then → RUN; wait counter cleared.
- HALT:
  - Identical outputs to IDLE; mem_err_o held at 1; exit only by reset. start_i is ignored.
- mem_ack_i outside MISS is ignored.
- Counters:
  - stall_cnt_o += 1 in every cycle with stall_all_o=1 (including IDLE/HALT) or with a load-use stall asserted.
  - flush_cnt_o += 1 in every cycle ifid_flush_o=1.
  - Both saturate at 2^COUNT_W-1; no wrap.
- Reset mid-MISS: FSM to IDLE immediately; mem_req_o drops asynchronously; an outstanding ack after reset is ignored.
- Control outputs are combinational from state+inputs. mem_req_o, mem_err_o and the counters are registered.

Test Plan:
- Reset, hold start_i=0 for 5 cycles → stall_all_o=1, pc_write_o=0, stall_cnt_o=5; then start_i=1 → RUN next cycle, pc_write_o=1.
- RUN, flush_i=1 and load_use_i=1 together → ifid_flush_o=1, pc_write_o=1, idex_bubble_o=1; flush_cnt_o +1.
- RUN, mem_access_i=1, mem_hit_i=0, ack 3 cycles later → stall_all_o high 4 cycles, mem_req_o single pulse in first MISS cycle, one RESUME cycle without re-miss despite mem_hit_i=0.
- Miss with no ack, TIMEOUT=4 → HALT after 4 MISS cycles; mem_err_o=1 sticky; start_i ignored; reset clears it.
- Miss during load_use_i=1 → load-use outputs suppressed while frozen, reapplied in RESUME (pc_write_o=0, idex_bubble_o=1).
- COUNT_W=3, hold stall 10 cycles → stall_cnt_o saturates at 7.
